alu_acc: RTL

ALU_ACC -- requirements
Module: alu_acc

---
 rtl/alu_acc_if.sv | 24 ++
 rtl/alu_acc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_if.sv
// Request/response bundle for the accumulator ALU.
// Master issues operations; slave returns registered results.
interface alu_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ALU_Out;
    logic             out_valid;
    logic [3:0]       flags;

    modport master (
        output in_valid, opcode, A, B,
        input  in_ready, ALU_Out, out_valid, flags
    );

    modport slave (
        input  in_valid, opcode, A, B,
        output in_ready, ALU_Out, out_valid, flags
    );
endinterface

// File: rtl/alu_acc.sv
// Accumulator ALU: single-cycle ops plus a shift-add multiplier.
// Flags are {N,V,C,Z}; MUL takes WIDTH cycles after accept.
module alu_acc #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_acc_if.slave bus
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_ROL = 4'h9;
    localparam logic [3:0] OP_ROR = 4'hA;
    localparam logic [3:0] OP_ACC = 4'hB;
    localparam logic [3:0] OP_LD  = 4'hC;
    localparam logic [3:0] OP_CMP = 4'hD;
    localparam logic [3:0] OP_INC = 4'hE;
    localparam logic [3:0] OP_DEC = 4'hF;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic [3:0]         flags_q, flags_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH-1:0]   add_a, add_b;
    logic               add_sub;
    logic [WIDTH:0]     sum;
    logic               ovf;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v;
    logic [2*WIDTH-1:0] prod_fin;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.ALU_Out   = alu_out_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;
    assign accept        = bus.in_valid & bus.in_ready;
    assign prod_fin      = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Shared adder/subtractor feeding all arithmetic ops and CMP.
    always_comb begin
        add_a   = bus.A;
        add_b   = bus.B;
        add_sub = 1'b0;
        case (bus.opcode)
            OP_SUB, OP_CMP: add_sub = 1'b1;
            OP_ACC: begin
                add_a = alu_out_q;
                add_b = bus.A;
            end
            OP_INC: add_b = WIDTH'(1);
            OP_DEC: begin
                add_b   = WIDTH'(1);
                add_sub = 1'b1;
            end
            default: ;
        endcase
        if (add_sub) begin
            sum = {1'b0, add_a} - {1'b0, add_b};
            ovf = (add_a[M] != add_b[M]) && (sum[M] != add_a[M]);
        end else begin
            sum = {1'b0, add_a} + {1'b0, add_b};
            ovf = (add_a[M] == add_b[M]) && (sum[M] != add_a[M]);
        end
    end

    // Single-cycle result, carry and overflow per opcode.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_SUB, OP_CMP,
            OP_ACC, OP_INC, OP_DEC: begin
                res   = sum[M:0];
                res_c = sum[WIDTH];
                res_v = ovf;
            end
            OP_AND: res = bus.A & bus.B;
            OP_OR:  res = bus.A | bus.B;
            OP_XOR: res = bus.A ^ bus.B;
            OP_NOT: res = ~bus.A;
            OP_SHL: begin
                res   = {bus.A[M-1:0], 1'b0};
                res_c = bus.A[M];
            end
            OP_SHR: begin
                res   = {1'b0, bus.A[M:1]};
                res_c = bus.A[0];
            end
            OP_ROL: begin
                res   = {bus.A[M-1:0], bus.A[M]};
                res_c = bus.A[M];
            end
            OP_ROR: begin
                res   = {bus.A[0], bus.A[M:1]};
                res_c = bus.A[0];
            end
            OP_LD:  res = bus.A;
            default: ;
        endcase
    end

    // Next-state: accept in IDLE, step the multiplier in MUL_BUSY.
    always_comb begin
        state_d     = state_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.opcode == OP_MUL) begin
                        state_d  = MUL_BUSY;
                        mcand_d  = {{WIDTH{1'b0}}, bus.A};
                        mplier_d = bus.B;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else begin
                        if (bus.opcode != OP_CMP) begin
                            alu_out_d = res;
                        end
                        flags_d     = {res[M], res_v, res_c, res == '0};
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                prod_d   = prod_fin;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    alu_out_d   = prod_fin[M:0];
                    flags_d     = {prod_fin[M], 1'b0,
                                   |prod_fin[2*WIDTH-1:WIDTH],
                                   prod_fin[M:0] == '0};
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_out_q   <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            prod_q      <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule
